// File: rtl/csa_seq_ctrl_if.sv
// Request/response bundle for csa_seq_ctrl: two requester channels and one tagged response channel.
interface csa_seq_ctrl_if #(
   parameter int unsigned NBYTES = 4
);
   localparam int unsigned W = 8 * NBYTES;

   logic         req0_valid;
   logic         req0_ready;
   logic [W-1:0] req0_a;
   logic [W-1:0] req0_b;
   logic         req0_cin;

   logic         req1_valid;
   logic         req1_ready;
   logic [W-1:0] req1_a;
   logic [W-1:0] req1_b;
   logic         req1_cin;

   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [W-1:0] rsp_sum;
   logic         rsp_cout;

   modport master (
      output req0_valid, req0_a, req0_b, req0_cin,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_cin,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
      output rsp_ready
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_cin,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_cin,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_sum, rsp_cout,
      input  rsp_ready
   );
endinterface

// File: rtl/csa_seq_ctrl.sv
// Multi-byte add sequencer: round-robin arbitrates two requesters and walks one shared
// 8-bit adder slice LSB first with a registered ripple carry between bytes.
module csa_seq_ctrl #(
   parameter int unsigned NBYTES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   csa_seq_ctrl_if.slave bus,
   output logic [7:0] add_x,
   output logic [7:0] add_y,
   output logic       add_cin,
   input  logic [7:0] add_sum,
   input  logic       add_cout
);

   localparam int unsigned W  = 8 * NBYTES;
   localparam int unsigned CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e        state_q;
   logic [W-1:0]  a_q, b_q, sum_q;
   logic [CW-1:0] cnt_q;
   logic          carry_q, id_q, cout_q, rsp_valid_q;
   logic          rr_q;  // 1: requester 1 wins a tie
   logic          grant0, grant1, last_byte;

   always_comb begin
      grant1 = bus.req1_valid & (~bus.req0_valid | rr_q);
      grant0 = bus.req0_valid & ~grant1;
   end

   assign bus.req0_ready = (state_q == StIdle) & grant0;
   assign bus.req1_ready = (state_q == StIdle) & grant1;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = id_q;
   assign bus.rsp_sum    = sum_q;
   assign bus.rsp_cout   = cout_q;

   assign last_byte = (cnt_q == CW'(NBYTES - 1));

   always_comb begin
      add_x   = '0;
      add_y   = '0;
      add_cin = 1'b0;
      if (state_q == StRun) begin
         add_cin = carry_q;
         for (int i = 0; i < NBYTES; i++) begin
            if (cnt_q == CW'(i)) begin
               add_x = a_q[8*i +: 8];
               add_y = b_q[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         id_q        <= 1'b0;
         cout_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rr_q        <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant0 | grant1) begin
                  a_q     <= grant1 ? bus.req1_a   : bus.req0_a;
                  b_q     <= grant1 ? bus.req1_b   : bus.req0_b;
                  carry_q <= grant1 ? bus.req1_cin : bus.req0_cin;
                  id_q    <= grant1;
                  rr_q    <= ~grant1;
                  cnt_q   <= '0;
                  state_q <= StRun;
               end
            end
            StRun: begin
               for (int i = 0; i < NBYTES; i++) begin
                  if (cnt_q == CW'(i)) sum_q[8*i +: 8] <= add_sum;
               end
               carry_q <= add_cout;
               if (last_byte) begin
                  cout_q      <= add_cout;
                  rsp_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDone: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_csa_seq_ctrl.sv
// Directed bench for csa_seq_ctrl: a 4-byte instance plus a 1-byte instance, each with a
// behavioural 8-bit adder slice.
module tb_csa_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   passed = 0;
   int   total  = 0;

   csa_seq_ctrl_if #(.NBYTES(4)) if0 ();
   csa_seq_ctrl_if #(.NBYTES(1)) if1 ();

   logic [7:0] ax0, ay0, as0, ax1, ay1, as1;
   logic       ac0, aco0, ac1, aco1;

   assign {aco0, as0} = {1'b0, ax0} + {1'b0, ay0} + {8'b0, ac0};
   assign {aco1, as1} = {1'b0, ax1} + {1'b0, ay1} + {8'b0, ac1};

   csa_seq_ctrl #(.NBYTES(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(if0),
      .add_x(ax0), .add_y(ay0), .add_cin(ac0), .add_sum(as0), .add_cout(aco0)
   );

   csa_seq_ctrl #(.NBYTES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1),
      .add_x(ax1), .add_y(ay1), .add_cin(ac1), .add_sum(as1), .add_cout(aco1)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b,
                        input logic cin);
      if (r == 0) begin
         if0.req0_valid = 1'b1; if0.req0_a = a; if0.req0_b = b; if0.req0_cin = cin;
      end else begin
         if0.req1_valid = 1'b1; if0.req1_a = a; if0.req1_b = b; if0.req1_cin = cin;
      end
   endtask

   // Steps until rsp_valid on the 4-byte instance; n = edges taken (30 on timeout).
   task automatic wait_rsp(output int n);
      n = 0;
      while (if0.rsp_valid !== 1'b1 && n < 30) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      if0.req0_valid = 0; if0.req0_a = 0; if0.req0_b = 0; if0.req0_cin = 0;
      if0.req1_valid = 0; if0.req1_a = 0; if0.req1_b = 0; if0.req1_cin = 0;
      if0.rsp_ready = 0;
      if1.req0_valid = 0; if1.req0_a = 0; if1.req0_b = 0; if1.req0_cin = 0;
      if1.req1_valid = 0; if1.req1_a = 0; if1.req1_b = 0; if1.req1_cin = 0;
      if1.rsp_ready = 1;
      #3;
      total++;
      if ({if0.rsp_valid, if0.rsp_id, if0.rsp_cout} !== 3'b000)
         $display("FAIL reset_rsp_flags: got %b required 000",
                  {if0.rsp_valid, if0.rsp_id, if0.rsp_cout});
      else passed++;
      total++;
      if (if0.rsp_sum !== 32'h0)
         $display("FAIL reset_rsp_sum: got %h required 00000000", if0.rsp_sum);
      else passed++;
      total++;
      if ({ax0, ay0, ac0} !== 17'h0)
         $display("FAIL reset_adder_drive: got %h required 0", {ax0, ay0, ac0});
      else passed++;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      step();
      total++;
      if ({if0.req1_ready, if0.req0_ready, if1.rsp_valid} !== 3'b000)
         $display("FAIL reset_ready_idle: got %b required 000",
                  {if0.req1_ready, if0.req0_ready, if1.rsp_valid});
      else passed++;
   endtask

   task automatic test_single_op();
      int n;
      issue(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      if0.rsp_ready = 1'b1;
      #1;
      total++;
      if ({if0.req1_ready, if0.req0_ready} !== 2'b01)
         $display("FAIL single_grant: got %b required 01", {if0.req1_ready, if0.req0_ready});
      else passed++;
      step();
      if0.req0_valid = 1'b0;
      total++;
      if ({ax0, ay0, ac0} !== {8'hFF, 8'h01, 1'b0})
         $display("FAIL single_first_byte: got %h required %h", {ax0, ay0, ac0},
                  {8'hFF, 8'h01, 1'b0});
      else passed++;
      wait_rsp(n);
      total++;
      if (n + 1 !== 5) $display("FAIL single_latency: got %0d required 5", n + 1);
      else passed++;
      total++;
      if ({if0.rsp_id, if0.rsp_cout, if0.rsp_sum} !== {1'b0, 1'b1, 32'h0})
         $display("FAIL single_result: got id %b cout %b sum %h required id 0 cout 1 sum 0",
                  if0.rsp_id, if0.rsp_cout, if0.rsp_sum);
      else passed++;
      step();
      total++;
      if (if0.rsp_valid !== 1'b0)
         $display("FAIL single_rsp_drop: got %b required 0", if0.rsp_valid);
      else passed++;
   endtask

   task automatic test_carry_in();
      int n;
      issue(1, 32'h1234_5678, 32'h0, 1'b1);
      #1;
      total++;
      if ({if0.req1_ready, if0.req0_ready} !== 2'b10)
         $display("FAIL cin_grant: got %b required 10", {if0.req1_ready, if0.req0_ready});
      else passed++;
      step();
      if0.req1_valid = 1'b0;
      total++;
      if ({ac0, ax0} !== {1'b1, 8'h78})
         $display("FAIL cin_first_byte: got cin %b x %h required cin 1 x 78", ac0, ax0);
      else passed++;
      wait_rsp(n);
      total++;
      if ({if0.rsp_id, if0.rsp_cout, if0.rsp_sum} !== {1'b1, 1'b0, 32'h1234_5679})
         $display("FAIL cin_result: got id %b cout %b sum %h required id 1 cout 0 sum 12345679",
                  if0.rsp_id, if0.rsp_cout, if0.rsp_sum);
      else passed++;
      step();
   endtask

   task automatic test_back_to_back();
      int n;
      logic stray;
      logic [31:0] exp_sum;
      logic exp_cout;
      issue(0, 32'h8000_0000, 32'h8000_0000, 1'b0);
      issue(1, 32'h00FF_00FF, 32'h0001_0001, 1'b0);
      #1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({if0.req1_ready, if0.req0_ready} !== ((i % 2 == 1) ? 2'b10 : 2'b01))
            $display("FAIL b2b_grant%0d: got %b required %b", i,
                     {if0.req1_ready, if0.req0_ready}, (i % 2 == 1) ? 2'b10 : 2'b01);
         else passed++;
         step();
         stray = 1'b0;
         n = 0;
         while (if0.rsp_valid !== 1'b1 && n < 30) begin
            if (if0.req0_ready | if0.req1_ready) stray = 1'b1;
            step();
            n++;
         end
         total++;
         if (stray !== 1'b0) $display("FAIL b2b_busy_ready%0d: got 1 required 0", i);
         else passed++;
         exp_sum  = (i % 2 == 1) ? 32'h0100_0100 : 32'h0;
         exp_cout = (i % 2 == 1) ? 1'b0 : 1'b1;
         total++;
         if ({if0.rsp_id, if0.rsp_cout, if0.rsp_sum} !== {i[0], exp_cout, exp_sum})
            $display("FAIL b2b_result%0d: got id %b cout %b sum %h required id %b cout %b sum %h",
                     i, if0.rsp_id, if0.rsp_cout, if0.rsp_sum, i[0], exp_cout, exp_sum);
         else passed++;
         step();
      end
      if0.req0_valid = 1'b0;
      if0.req1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      int n;
      logic bad;
      issue(0, 32'h1111_1111, 32'h2222_2222, 1'b0);
      if0.rsp_ready = 1'b0;
      #1;
      step();
      if0.req0_valid = 1'b0;
      issue(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
      wait_rsp(n);
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (if0.rsp_valid !== 1'b1 || if0.rsp_sum !== 32'h3333_3333 || if0.rsp_cout !== 1'b0
             || if0.rsp_id !== 1'b0 || if0.req0_ready !== 1'b0 || if0.req1_ready !== 1'b0)
            bad = 1'b1;
         step();
      end
      total++;
      if (bad !== 1'b0)
         $display("FAIL bp_hold: got unstable/ready during stall, required stable with no ready");
      else passed++;
      if0.rsp_ready = 1'b1;
      step();
      total++;
      if ({if0.rsp_valid, if0.req1_ready} !== 2'b01)
         $display("FAIL bp_release: got valid %b ready1 %b required valid 0 ready1 1",
                  if0.rsp_valid, if0.req1_ready);
      else passed++;
      step();
      if0.req1_valid = 1'b0;
      total++;
      if (ax0 !== 8'hFF) $display("FAIL bp_next_accept: got x %h required ff", ax0);
      else passed++;
      wait_rsp(n);
      total++;
      if ({if0.rsp_id, if0.rsp_cout, if0.rsp_sum} !== {1'b1, 1'b0, 32'h0001_0000})
         $display("FAIL bp_next_result: got id %b cout %b sum %h required id 1 cout 0 sum 00010000",
                  if0.rsp_id, if0.rsp_cout, if0.rsp_sum);
      else passed++;
      step();
   endtask

   task automatic test_reset_mid_run();
      int n;
      issue(0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
      #1;
      step();
      if0.req0_valid = 1'b0;
      step();
      step();
      total++;
      if ({ax0, ay0} !== 16'hAA55)
         $display("FAIL rst_run_byte2: got %h required aa55", {ax0, ay0});
      else passed++;
      rst_n = 1'b0;
      #1;
      total++;
      if ({if0.rsp_valid, ax0, ay0, ac0} !== 18'h0)
         $display("FAIL rst_async_clear: got %h required 0", {if0.rsp_valid, ax0, ay0, ac0});
      else passed++;
      @(posedge clk);
      #3 rst_n = 1'b1;
      issue(0, 32'h0102_0304, 32'h1020_3040, 1'b0);
      issue(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
      #1;
      total++;
      if ({if0.req1_ready, if0.req0_ready} !== 2'b01)
         $display("FAIL rst_tie_priority: got %b required 01", {if0.req1_ready, if0.req0_ready});
      else passed++;
      step();
      if0.req0_valid = 1'b0;
      wait_rsp(n);
      total++;
      if ({if0.rsp_id, if0.rsp_cout, if0.rsp_sum} !== {1'b0, 1'b0, 32'h1122_3344})
         $display("FAIL rst_req0_result: got id %b cout %b sum %h required id 0 cout 0 sum 11223344",
                  if0.rsp_id, if0.rsp_cout, if0.rsp_sum);
      else passed++;
      step();
      step();
      if0.req1_valid = 1'b0;
      wait_rsp(n);
      total++;
      if ({if0.rsp_id, if0.rsp_cout, if0.rsp_sum} !== {1'b1, 1'b0, 32'h8000_0001})
         $display("FAIL rst_req1_result: got id %b cout %b sum %h required id 1 cout 0 sum 80000001",
                  if0.rsp_id, if0.rsp_cout, if0.rsp_sum);
      else passed++;
      step();
   endtask

   task automatic test_nbytes1();
      int n;
      if1.req0_valid = 1'b1; if1.req0_a = 8'hF0; if1.req0_b = 8'h20; if1.req0_cin = 1'b0;
      #1;
      total++;
      if (if1.req0_ready !== 1'b1) $display("FAIL nb1_grant: got %b required 1", if1.req0_ready);
      else passed++;
      step();
      if1.req0_valid = 1'b0;
      n = 1;
      while (if1.rsp_valid !== 1'b1 && n < 30) begin
         step();
         n++;
      end
      total++;
      if (n !== 2) $display("FAIL nb1_latency: got %0d required 2", n);
      else passed++;
      total++;
      if ({if1.rsp_id, if1.rsp_cout, if1.rsp_sum} !== {1'b0, 1'b1, 8'h10})
         $display("FAIL nb1_result: got id %b cout %b sum %h required id 0 cout 1 sum 10",
                  if1.rsp_id, if1.rsp_cout, if1.rsp_sum);
      else passed++;
      step();
      total++;
      if (if1.rsp_valid !== 1'b0) $display("FAIL nb1_rsp_drop: got %b required 0", if1.rsp_valid);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_carry_in();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_run();
      test_nbytes1();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/csa_seq_ctrl.md
# csa_seq_ctrl

Multi-byte add sequencer and two-port arbiter for the team's 8-bit conditional-sum adder slice. It accepts wide add requests from two requesters over valid/ready handshakes. Each operation runs through one shared external 8-bit adder, one byte per cycle, LSB first, with a registered ripple carry between bytes. The finished sum and carry-out go back on a single response channel tagged with the requester id. It sits between the bus-side requesters and the adder datapath, which stays purely combinational.

## Interface
- NBYTES, 4, operand width in bytes (≥1); operand width W = 8*NBYTES
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous and active-low
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 accepted this cycle
- req0_a, req0_b  input  W  requester 0 operands
- req0_cin  input  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0, for requester 1
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes the result
- rsp_id  output  1  requester that owns the result
- rsp_sum  output  W  sum
- rsp_cout  output  1  final carry-out
- add_x, add_y  output  8  operand bytes to the adder slice
- add_cin  output  1  carry into the adder slice
- add_sum  input  8  adder slice sum, combinational, same cycle
- add_cout  input  1  adder slice carry-out, combinational, same cycle

## Operation
- Three states: IDLE, RUN, DONE. Reset enters IDLE.
- **IDLE arbitration:** round-robin over the valid requesters. The requester not granted last time wins a tie. After reset, requester 0 has priority.
- **IDLE outputs:** reqN_ready = 1 only for the granted requester, combinational from the valids, never both. No ready is asserted if neither is valid.
- **Accept (IDLE, granted valid & ready):** latch a, b, cin and id; clear the byte counter; update the round-robin pointer; go to RUN.
- **RUN, counter k:**
  - add_x = a[8k+7:8k], add_y = b[8k+7:8k], add_cin = carry register (the latched cin when k = 0).
  - Clock edge: sum[8k+7:8k] ← add_sum, carry ← add_cout, k ← k+1.
  - When k = NBYTES−1, go to DONE instead. rsp_cout ← add_cout.
- **Outside RUN:** add_x, add_y and add_cin are driven to 0.
- **DONE:** rsp_valid = 1. rsp_id, rsp_sum and rsp_cout hold stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE. No new accept happens in the same cycle.
- **Backpressure:** requests arriving during RUN or DONE wait. The requester must hold valid and operands stable until it sees ready.
- **Arithmetic:** modulo 2^W. rsp_cout is the carry out of bit W−1. No overflow flag.
- **Counter:** width is max(1, clog2(NBYTES)). It never wraps past NBYTES−1.
- **NBYTES = 1:** RUN lasts exactly one cycle.
- **Reset mid-operation:** the op in flight is dropped with no response. rsp_valid = 0 immediately, since reset is asynchronous.

## Timing
- **Reset values:**
  - req0_ready = req1_ready = 0 registered part; they are combinational in IDLE, so they follow the valids once rst_n is high.
  - rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_cout = 0.
  - add_x = add_y = 0, add_cin = 0.
  - Round-robin pointer set for requester 0 priority.
- **Latency:** with the accept edge at cycle T, RUN spans cycles T+1..T+NBYTES. rsp_valid rises in cycle T+NBYTES+1. For NBYTES = 4 this is 5 cycles accept-to-response.
- **Throughput:** at best one op per NBYTES+2 cycles, because IDLE takes one cycle between ops.
- **Adder path:** one combinational pass through the adder slice per cycle, registered in this block. The critical path is register → 8-bit adder slice → register.

## Test plan
- **Single op:** req0 a=0xFFFFFFFF, b=0x00000001, cin=0, rsp_ready=1 -> rsp_valid 5 cycles after accept, sum=0x00000000, cout=1, id=0.
- **Carry-in only:** req1 a=0x12345678, b=0x00000000, cin=1 -> sum=0x12345679, cout=0, id=1. The bench also checks add_cin=1 in the first RUN cycle.
- **Simultaneous requests, both valid continuously:**
  - Grants go 0,1,0,1.
  - Results are a=0x80000000+b=0x80000000 -> sum 0, cout 1, and a=0x00FF00FF+b=0x00010001 -> 0x01000100, cout 0.
  - The non-granted ready stays 0.
- **Backpressure:** hold rsp_ready=0 for 10 cycles in DONE -> outputs stable, no reqN_ready asserted. After rsp_ready=1, return to IDLE and the next accept comes one cycle later.
- **Reset mid-RUN:** drop rst_n at k=2 -> rsp_valid=0 and add_* = 0 immediately. After release, a new req1 op completes correctly and req0 has priority on a tie.
- **NBYTES=1 build:** a=0xF0, b=0x20 -> sum 0x10, cout 1, rsp_valid 2 cycles after accept.
